// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain
// Purpose  : Pops bytes from the TX FIFO read port and serialises each one as
//            an asynchronous UART frame (start, 7/8 data, opt. parity, stop).
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo_drain #(
    parameter int FIFO_RD_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_clock,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rdb,
    output logic       tx,
    output logic       tx_busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    localparam logic [1:0] c_RD_LAT = 2'(FIFO_RD_LATENCY);

    state_t     r_state,     w_state_nxt;
    logic [1:0] r_lat_cnt,   w_lat_cnt_nxt;
    logic [3:0] r_tick,      w_tick_nxt;
    logic [3:0] r_bit_cnt,   w_bit_cnt_nxt;
    logic [7:0] r_shift,     w_shift_nxt;
    logic       r_bit8,      w_bit8_nxt;
    logic       r_par_en,    w_par_en_nxt;
    logic       r_par_bit,   w_par_bit_nxt;
    logic       r_rdb,       w_rdb_nxt;
    logic       r_tx,        w_tx_nxt;
    logic       r_busy,      w_busy_nxt;

    logic [7:0] w_data_bits;
    logic       w_par_bit;
    logic       w_in_frame;
    logic       w_bit_end;
    logic [3:0] w_nbits;

    // In 7-bit mode bit 7 is forced to zero so it neither shifts out nor
    // contributes to parity.
    assign w_data_bits = bit8 ? fifo_data : {1'b0, fifo_data[6:0]};
    assign w_par_bit   = (^w_data_bits) ^ odd_n_even;

    assign w_in_frame  = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_bit_end   = baud_clock && (r_tick == 4'd15);
    assign w_nbits     = r_bit8 ? 4'd8 : 4'd7;

    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_tick_nxt    = r_tick;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_bit8_nxt    = r_bit8;
        w_par_en_nxt  = r_par_en;
        w_par_bit_nxt = r_par_bit;
        w_rdb_nxt     = 1'b1;
        w_tx_nxt      = r_tx;
        w_busy_nxt    = r_busy;

        // Ticks only advance while a frame is on the line; the counter wraps
        // 15 -> 0 on the same pulse that ends a bit.
        if (w_in_frame && baud_clock) begin
            w_tick_nxt = r_tick + 4'd1;
        end

        case (r_state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    w_rdb_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_lat_cnt_nxt = 2'd0;
                    w_state_nxt   = S_FETCH;
                end
            end

            S_FETCH: begin
                if (r_lat_cnt == c_RD_LAT) begin
                    w_shift_nxt   = w_data_bits;
                    w_bit8_nxt    = bit8;
                    w_par_en_nxt  = parity_en;
                    w_par_bit_nxt = w_par_bit;
                    w_tx_nxt      = 1'b0;
                    w_tick_nxt    = 4'd0;
                    w_bit_cnt_nxt = 4'd0;
                    w_state_nxt   = S_START;
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt + 2'd1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nxt = 4'd1;
                    w_state_nxt   = S_DATA;
                end
            end

            S_DATA: begin
                // r_bit_cnt is the number of data bits already placed on tx.
                if (w_bit_end) begin
                    if (r_bit_cnt == w_nbits) begin
                        if (r_par_en) begin
                            w_tx_nxt    = r_par_bit;
                            w_state_nxt = S_PARITY;
                        end else begin
                            w_tx_nxt    = 1'b1;
                            w_state_nxt = S_STOP;
                        end
                    end else begin
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
            end

            S_PARITY: begin
                if (w_bit_end) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lat_cnt <= 2'd0;
            r_tick    <= 4'd0;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_bit8    <= 1'b0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_rdb     <= 1'b1;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_bit8    <= w_bit8_nxt;
            r_par_en  <= w_par_en_nxt;
            r_par_bit <= w_par_bit_nxt;
            r_rdb     <= w_rdb_nxt;
            r_tx      <= w_tx_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign fifo_rdb = r_rdb;
    assign tx       = r_tx;
    assign tx_busy  = r_busy;

endmodule
`default_nettype wire
